// File: rtl/dac_pkg.sv
// Shared register map, waveform codes, FSM states and staging payload for the DAC sweep controller.
package dac_pkg;

    localparam int unsigned REG_IDX_W  = 3;
    localparam int unsigned ROM_ADDR_W = 14;
    localparam int unsigned AMP_W      = 14;
    localparam int unsigned DUTY_W     = 8;
    localparam int unsigned WAVE_W     = 2;

    localparam logic [REG_IDX_W-1:0] REG_CTRL      = 3'd0;
    localparam logic [REG_IDX_W-1:0] REG_FTW_START = 3'd1;
    localparam logic [REG_IDX_W-1:0] REG_FTW_STOP  = 3'd2;
    localparam logic [REG_IDX_W-1:0] REG_FTW_STEP  = 3'd3;
    localparam logic [REG_IDX_W-1:0] REG_AMP       = 3'd4;
    localparam logic [REG_IDX_W-1:0] REG_DUTY      = 3'd5;
    localparam logic [REG_IDX_W-1:0] REG_DWELL     = 3'd6;

    localparam logic [WAVE_W-1:0] WAVE_SINE   = 2'b00;
    localparam logic [WAVE_W-1:0] WAVE_SQUARE = 2'b01;
    localparam logic [WAVE_W-1:0] WAVE_TRI    = 2'b10;

    localparam int unsigned DUTY_MAX = 100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SWEEP = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // Waveform parameters staged toward the ROM as one unit.
    typedef struct packed {
        logic [AMP_W-1:0]  amp;
        logic [DUTY_W-1:0] duty;
        logic [WAVE_W-1:0] wave;
    } stage_t;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
        return (d > DUTY_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : d;
    endfunction

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator: acc += ftw each enabled cycle, wrap is the registered carry-out of that add.
module phase_acc #(
    parameter int unsigned PHASE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               run,
    input  logic [PHASE_W-1:0] ftw,
    output logic [PHASE_W-1:0] acc,
    output logic               wrap,
    output logic               carry_c
);

    logic [PHASE_W:0] sum;

    assign sum     = {1'b0, acc} + {1'b0, ftw};
    assign carry_c = run & sum[PHASE_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else if (clear) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else if (run) begin
            acc  <= sum[PHASE_W-1:0];
            wrap <= carry_c;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS phase/sweep controller: register file, RUN/SWEEP/HOLD FSM and wrap-aligned staging of
// amplitude, duty and waveform select toward the waveform ROM.
module dds_sweep_ctrl
    import dac_pkg::*;
#(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned DWELL_W = 24
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [REG_IDX_W-1:0]  wr_addr,
    input  logic [31:0]           wr_data,
    output logic [ROM_ADDR_W-1:0] rom_address,
    output logic [AMP_W-1:0]      rom_amplitude,
    output logic [WAVE_W-1:0]     rom_wave_sel,
    output logic [DUTY_W-1:0]     rom_duty,
    output logic                  phase_wrap,
    output logic                  sweep_done,
    output logic                  busy
);

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] ftw_start_q, ftw_stop_q, ftw_step_q;
    logic [PHASE_W-1:0] cur_ftw_q, cur_ftw_d;
    logic [DWELL_W-1:0] dwell_q, dwell_lim;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [PHASE_W:0]   step_sum;
    logic               loop_q;
    stage_t             shadow_q, shadow_d;
    logic               ctrl_wr, done_d, stage;
    logic [PHASE_W-1:0] acc;
    logic               carry_c;

    assign ctrl_wr   = wr_en && (wr_addr == REG_CTRL);
    assign dwell_lim = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

    phase_acc #(.PHASE_W(PHASE_W)) u_phase_acc (
        .clk     (sys_clk),
        .rst     (rst),
        .clear   (ctrl_wr),
        .run     (state_q != IDLE),
        .ftw     (cur_ftw_q),
        .acc     (acc),
        .wrap    (phase_wrap),
        .carry_c (carry_c)
    );

    // Shadow values including this cycle's write, so a write is never lost on a staging edge.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_en) begin
            case (wr_addr)
                REG_CTRL: shadow_d.wave = wr_data[4:3];
                REG_AMP:  shadow_d.amp  = wr_data[AMP_W-1:0];
                REG_DUTY: shadow_d.duty = clamp_duty(wr_data[DUTY_W-1:0]);
                default:  ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ftw_start_q <= '0;
            ftw_stop_q  <= '0;
            ftw_step_q  <= '0;
            dwell_q     <= '0;
            loop_q      <= 1'b0;
            shadow_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            if (wr_en) begin
                case (wr_addr)
                    REG_CTRL:      loop_q      <= wr_data[2];
                    REG_FTW_START: ftw_start_q <= PHASE_W'(wr_data);
                    REG_FTW_STOP:  ftw_stop_q  <= PHASE_W'(wr_data);
                    REG_FTW_STEP:  ftw_step_q  <= PHASE_W'(wr_data);
                    REG_DWELL:     dwell_q     <= DWELL_W'(wr_data);
                    default:       ;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_ftw_q   <= '0;
            dwell_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_ftw_q   <= cur_ftw_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_ftw_d   = cur_ftw_q;
        dwell_cnt_d = dwell_cnt_q;
        done_d      = 1'b0;
        stage       = 1'b0;
        step_sum    = {1'b0, cur_ftw_q} + {1'b0, ftw_step_q};
        case (state_q)
            IDLE: stage = 1'b1;
            RUN: begin
                stage = carry_c;
                if (carry_c) cur_ftw_d = ftw_start_q;
            end
            SWEEP: begin
                stage = carry_c;
                if (dwell_cnt_q >= dwell_lim) begin
                    dwell_cnt_d = '0;
                    // A carry out of the step add always counts as reaching the stop frequency.
                    if (step_sum >= {1'b0, ftw_stop_q}) begin
                        done_d = 1'b1;
                        if (loop_q) begin
                            cur_ftw_d = ftw_start_q;
                        end else begin
                            cur_ftw_d = ftw_stop_q;
                            state_d   = HOLD;
                        end
                    end else begin
                        cur_ftw_d = step_sum[PHASE_W-1:0];
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end
            end
            HOLD: stage = carry_c;
            default: state_d = IDLE;
        endcase
        // A CTRL write restarts or stops from any state and overrides the sweep step.
        if (ctrl_wr) begin
            stage       = (state_q == IDLE);
            done_d      = 1'b0;
            dwell_cnt_d = '0;
            cur_ftw_d   = ftw_start_q;
            if (!wr_data[0]) begin
                state_d = IDLE;
            end else if (!wr_data[1]) begin
                state_d = RUN;
            end else if (ftw_stop_q <= ftw_start_q) begin
                done_d = 1'b1;
                if (wr_data[2]) begin
                    state_d = SWEEP;
                end else begin
                    state_d   = HOLD;
                    cur_ftw_d = ftw_stop_q;
                end
            end else begin
                state_d = SWEEP;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rom_address   <= '0;
            rom_amplitude <= '0;
            rom_duty      <= '0;
            rom_wave_sel  <= WAVE_SINE;
            sweep_done    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rom_address <= ctrl_wr ? '0 : acc[PHASE_W-1 -: ROM_ADDR_W];
            if (stage) begin
                rom_amplitude <= shadow_d.amp;
                rom_duty      <= shadow_d.duty;
                rom_wave_sel  <= shadow_d.wave;
            end
            sweep_done <= done_d;
            busy       <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Randomized and directed bench for dds_sweep_ctrl against a cycle-level arithmetic reference model.
module tb_dds_sweep_ctrl;

    logic        sys_clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [13:0] rom_address;
    logic [13:0] rom_amplitude;
    logic [1:0]  rom_wave_sel;
    logic [7:0]  rom_duty;
    logic        phase_wrap;
    logic        sweep_done;
    logic        busy;

    dds_sweep_ctrl dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rom_address   (rom_address),
        .rom_amplitude (rom_amplitude),
        .rom_wave_sel  (rom_wave_sel),
        .rom_duty      (rom_duty),
        .phase_wrap    (phase_wrap),
        .sweep_done    (sweep_done),
        .busy          (busy)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: generator is off, running at a fixed frequency, sweeping, or parked at stop.
    typedef enum {M_OFF, M_FIXED, M_SWEEP, M_PARKED} mode_t;
    localparam longint TWO32 = 64'h1_0000_0000;

    mode_t  m_mode;
    longint m_acc, m_ftw, m_start, m_stop, m_step;
    int     m_dwell, m_dcnt;
    bit     m_loop;
    int     m_amp, m_duty, m_wave;
    logic [13:0] e_addr, e_amp;
    logic [1:0]  e_wave;
    logic [7:0]  e_duty;
    logic        e_wrap, e_done, e_busy;

    task automatic model_reset();
        m_mode = M_OFF; m_acc = 0; m_ftw = 0; m_start = 0; m_stop = 0; m_step = 0;
        m_dwell = 0; m_dcnt = 0; m_loop = 0; m_amp = 0; m_duty = 0; m_wave = 0;
        e_addr = 0; e_amp = 0; e_wave = 0; e_duty = 0; e_wrap = 0; e_done = 0; e_busy = 0;
    endtask

    task automatic model_step(input bit we, input logic [2:0] a, input logic [31:0] d);
        longint sum;
        bit     carry, ctrl, stage;
        int     n_amp, n_duty, n_wave, lim;
        ctrl   = we && (a == 3'd0);
        n_amp  = (we && a == 3'd4) ? int'(d[13:0]) : m_amp;
        n_duty = (we && a == 3'd5) ? ((d[7:0] > 8'd100) ? 100 : int'(d[7:0])) : m_duty;
        n_wave = ctrl ? int'(d[4:3]) : m_wave;
        sum    = m_acc + m_ftw;
        carry  = (m_mode != M_OFF) && (sum >= TWO32);
        stage  = (m_mode == M_OFF) || (carry && !ctrl);
        if (stage) begin
            e_amp = 14'(n_amp); e_duty = 8'(n_duty); e_wave = 2'(n_wave);
        end
        e_addr = ctrl ? 14'd0 : 14'(m_acc >> 18);
        e_wrap = 0;
        e_done = 0;
        if (ctrl) begin
            m_acc = 0; m_dcnt = 0;
            if (!d[0]) m_mode = M_OFF;
            else begin
                m_ftw = m_start;
                if (!d[1]) m_mode = M_FIXED;
                else if (m_stop <= m_start) begin
                    e_done = 1;
                    if (d[2]) m_mode = M_SWEEP;
                    else begin m_mode = M_PARKED; m_ftw = m_stop; end
                end else m_mode = M_SWEEP;
            end
        end else if (m_mode != M_OFF) begin
            m_acc  = sum % TWO32;
            e_wrap = carry;
            if (m_mode == M_FIXED && carry) m_ftw = m_start;
            if (m_mode == M_SWEEP) begin
                lim = (m_dwell == 0) ? 1 : m_dwell;
                if (m_dcnt + 1 >= lim) begin
                    m_dcnt = 0;
                    if (m_ftw + m_step >= m_stop) begin
                        e_done = 1;
                        if (m_loop) m_ftw = m_start;
                        else begin m_ftw = m_stop; m_mode = M_PARKED; end
                    end else m_ftw = m_ftw + m_step;
                end else m_dcnt++;
            end
        end
        m_amp = n_amp; m_duty = n_duty; m_wave = n_wave;
        if (we) begin
            case (a)
                3'd0: m_loop  = d[2];
                3'd1: m_start = longint'(d);
                3'd2: m_stop  = longint'(d);
                3'd3: m_step  = longint'(d);
                3'd6: m_dwell = int'(d[23:0]);
                default: ;
            endcase
        end
        e_busy = (m_mode != M_OFF);
    endtask

    function automatic logic [40:0] dut_outs();
        return {rom_address, rom_amplitude, rom_wave_sel, rom_duty, phase_wrap, sweep_done, busy};
    endfunction

    function automatic logic [40:0] exp_outs();
        return {e_addr, e_amp, e_wave, e_duty, e_wrap, e_done, e_busy};
    endfunction

    task automatic cycle(input bit we, input logic [2:0] a, input logic [31:0] d);
        wr_en = we; wr_addr = a; wr_data = d;
        @(posedge sys_clk);
        #1;
        model_step(we, a, d);
        check("outputs", 64'(dut_outs()), 64'(exp_outs()));
        wr_en = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cycle(1'b1, a, d);
    endtask

    task automatic idle();
        cycle(1'b0, 3'd0, 32'd0);
    endtask

    int first_ev, second_ev, n_ev;
    logic [13:0] old_amp;
    logic [2:0]  ra;
    logic [31:0] rd;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        check("reset_outs", 64'(dut_outs()), 64'd0);
        rst = 1'b0;

        // Fixed frequency 2^18: one address step per cycle, wrap after 16384 adds.
        wr(3'd1, 32'h0004_0000);
        wr(3'd0, 32'h1);
        first_ev = -1; n_ev = 0;
        for (int k = 1; k <= 16400; k++) begin
            idle();
            if (k == 2) check("addr_e2", 64'(rom_address), 64'd1);
            if (k == 3) check("addr_e3", 64'(rom_address), 64'd2);
            if (phase_wrap) begin
                n_ev++;
                if (first_ev < 0) first_ev = k;
            end
        end
        check("first_wrap", 64'(first_ev), 64'd16384);
        check("wrap_count", 64'(n_ev), 64'd1);

        // Amplitude written mid-period only appears on the wrap cycle.
        wr(3'd1, 32'h1000_0000);
        wr(3'd0, 32'h1);
        repeat (5) idle();
        old_amp = rom_amplitude;
        wr(3'd4, 32'h1000);
        first_ev = -1;
        for (int k = 0; k < 20 && first_ev < 0; k++) begin
            idle();
            if (phase_wrap) begin
                first_ev = k;
                check("amp_at_wrap", 64'(rom_amplitude), 64'h1000);
            end else begin
                check("amp_held", 64'(rom_amplitude), 64'(old_amp));
            end
        end
        check("amp_wrap_seen", 64'(first_ev >= 0), 64'd1);

        // Single sweep 2^20 -> 2^21, step 2^18, dwell 10: done after 40 cycles, then HOLD.
        wr(3'd1, 32'h0010_0000);
        wr(3'd2, 32'h0020_0000);
        wr(3'd3, 32'h0004_0000);
        wr(3'd6, 32'd10);
        wr(3'd0, 32'h3);
        first_ev = -1; n_ev = 0;
        for (int k = 1; k <= 100; k++) begin
            idle();
            if (sweep_done) begin
                n_ev++;
                if (first_ev < 0) first_ev = k;
            end
        end
        check("sweep_done_at", 64'(first_ev), 64'd40);
        check("sweep_done_cnt", 64'(n_ev), 64'd1);
        check("hold_busy", 64'(busy), 64'd1);

        // Looping sweep: done every 40 cycles.
        wr(3'd0, 32'h7);
        first_ev = -1; second_ev = -1; n_ev = 0;
        for (int k = 1; k <= 130; k++) begin
            idle();
            if (sweep_done) begin
                n_ev++;
                if (first_ev < 0) first_ev = k;
                else if (second_ev < 0) second_ev = k;
            end
        end
        check("loop_first", 64'(first_ev), 64'd40);
        check("loop_second", 64'(second_ev), 64'd80);
        check("loop_count", 64'(n_ev), 64'd3);

        // Disable, duty clamp, then dwell 0 steps every cycle.
        wr(3'd0, 32'h0);
        check("disable_busy", 64'(busy), 64'd0);
        check("disable_addr", 64'(rom_address), 64'd0);
        wr(3'd5, 32'd150);
        idle();
        check("duty_clamp", 64'(rom_duty), 64'd100);
        wr(3'd6, 32'd0);
        wr(3'd0, 32'h3);
        first_ev = -1;
        for (int k = 1; k <= 10; k++) begin
            idle();
            if (sweep_done && first_ev < 0) first_ev = k;
        end
        check("dwell0_done", 64'(first_ev), 64'd4);

        // Asynchronous reset in the middle of a looping sweep.
        wr(3'd0, 32'h1F);
        repeat (25) idle();
        #2 rst = 1'b1;
        #1 check("async_reset", 64'(dut_outs()), 64'd0);
        @(posedge sys_clk);
        #1 rst = 1'b0;
        model_reset();
        wr(3'd1, 32'h0100_0000);
        wr(3'd0, 32'h1);
        repeat (10) idle();
        wr(3'd0, 32'h0);
        check("stop_addr", 64'(rom_address), 64'd0);
        check("stop_busy", 64'(busy), 64'd0);

        // Randomized register traffic against the model.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(11) == 0) begin
                ra = 3'($urandom_range(7));
                case (ra)
                    3'd0: rd = {27'd0, 2'($urandom_range(2)), 1'($urandom_range(1)),
                                1'($urandom_range(1)), 1'($urandom_range(7) != 0)};
                    3'd1: rd = $urandom >> 4;
                    3'd3: rd = $urandom >> 4;
                    3'd5: rd = 32'($urandom_range(255));
                    3'd6: rd = 32'($urandom_range(5));
                    default: rd = $urandom;
                endcase
                if (ra == 3'd0 && $urandom_range(3) != 0) ra = 3'd4;
                cycle(1'b1, ra, rd);
            end else begin
                idle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
